// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
// Word-addressed data memory for the MEM stage. It accepts one request at a
// time, answers with a single-cycle response strobe and raises mem_stall
// until that strobe so the pipeline holds.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 2..256)
//   WAIT_CYCLES  extra response latency (0..15), only with DMEM_WAIT_STATES_EN
//
// Build option
//   DMEM_WAIT_STATES_EN  defined   : IDLE -> WAIT -> RESP, WAIT_CYCLES extra cycles
//                        undefined : IDLE -> RESP, response one cycle after capture
//
// Ports
//   clk, reset              single clock, synchronous active-high reset
//   req_valid/we/addr/wdata request (byte address, store data)
//   req_ready               high only in IDLE and not in reset (combinational)
//   resp_valid/rdata/err    registered one-cycle response; err = misaligned
//   mem_stall               req_valid & ~resp_valid (combinational)
// ----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int unsigned DEPTH       = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_stall
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 4;

`ifdef DMEM_WAIT_STATES_EN
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // A zero latency build behaves exactly like the build without WAIT
   localparam bit HAS_WAIT = (WAIT_CYCLES != 0);
`else
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_e;
`endif

   state_e      state_q, state_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_err_q,   resp_err_d;
   logic [31:0] mem_q [DEPTH];
   logic [31:0] mem_d [DEPTH];

`ifdef DMEM_WAIT_STATES_EN
   logic [CW-1:0] cnt_q,       cnt_d;
   logic          cap_we_q,    cap_we_d;
   logic          cap_mis_q,   cap_mis_d;
   logic [AW-1:0] cap_idx_q,   cap_idx_d;
   logic [31:0]   cap_wdata_q, cap_wdata_d;
`else
   logic unused_wait_cfg;
   assign unused_wait_cfg = (WAIT_CYCLES > 32'd15);
`endif

   // Request decode: word index wraps modulo DEPTH, upper bits are dropped
   logic [AW-1:0] req_idx;
   logic          req_mis;
   logic          unused_addr_hi;

   assign req_idx        = req_addr[AW+1:2];
   assign req_mis        = |req_addr[1:0];
   assign unused_addr_hi = ^req_addr[31:AW+2];

   // The access that is performed on the edge entering RESP
   logic          acc_go;
   logic          acc_we;
   logic          acc_mis;
   logic [AW-1:0] acc_idx;
   logic [31:0]   acc_wdata;

   // Next-state, array commit and response generation
   always_comb begin
      state_d      = state_q;
      resp_valid_d = 1'b0;
      resp_rdata_d = 32'h0;
      resp_err_d   = 1'b0;
      mem_d        = mem_q;
      acc_go       = 1'b0;
      acc_we       = req_we;
      acc_mis      = req_mis;
      acc_idx      = req_idx;
      acc_wdata    = req_wdata;
`ifdef DMEM_WAIT_STATES_EN
      cnt_d        = cnt_q;
      cap_we_d     = cap_we_q;
      cap_mis_d    = cap_mis_q;
      cap_idx_d    = cap_idx_q;
      cap_wdata_d  = cap_wdata_q;
`endif

      case (state_q)
         IDLE: begin
            if (req_valid) begin
`ifdef DMEM_WAIT_STATES_EN
               if (HAS_WAIT) begin
                  state_d     = WAIT;
                  cnt_d       = CW'(WAIT_CYCLES - 1);
                  cap_we_d    = req_we;
                  cap_mis_d   = req_mis;
                  cap_idx_d   = req_idx;
                  cap_wdata_d = req_wdata;
               end else begin
                  state_d = RESP;
                  acc_go  = 1'b1;
               end
`else
               state_d = RESP;
               acc_go  = 1'b1;
`endif
            end
         end
`ifdef DMEM_WAIT_STATES_EN
         WAIT: begin
            // Request inputs are ignored here; the captured copy is used
            acc_we    = cap_we_q;
            acc_mis   = cap_mis_q;
            acc_idx   = cap_idx_q;
            acc_wdata = cap_wdata_q;
            if (cnt_q == CW'(0)) begin
               state_d = RESP;
               acc_go  = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
`endif
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Store commits and load reads happen together on the RESP entry edge
      if (acc_go) begin
         resp_valid_d = 1'b1;
         resp_err_d   = acc_mis;
         if (!acc_mis) begin
            if (acc_we) begin
               mem_d[acc_idx] = acc_wdata;
            end else begin
               resp_rdata_d = mem_q[acc_idx];
            end
         end
      end
   end

   // State and storage registers; reset wins over everything
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0;
         resp_err_q   <= 1'b0;
         mem_q        <= '{default: 32'h0};
`ifdef DMEM_WAIT_STATES_EN
         cnt_q        <= '0;
         cap_we_q     <= 1'b0;
         cap_mis_q    <= 1'b0;
         cap_idx_q    <= '0;
         cap_wdata_q  <= 32'h0;
`endif
      end else begin
         state_q      <= state_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         mem_q        <= mem_d;
`ifdef DMEM_WAIT_STATES_EN
         cnt_q        <= cnt_d;
         cap_we_q     <= cap_we_d;
         cap_mis_q    <= cap_mis_d;
         cap_idx_q    <= cap_idx_d;
         cap_wdata_q  <= cap_wdata_d;
`endif
      end
   end

   assign req_ready  = (state_q == IDLE) && !reset;
   assign mem_stall  = req_valid && !resp_valid_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
// Self-checking bench for data_mem_responder: directed cases followed by
// random loads/stores, compared against a word-array reference model.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int unsigned DEPTH       = 32;
   localparam int unsigned WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_STATES_EN
   localparam int unsigned LAT = WAIT_CYCLES;
`else
   localparam int unsigned LAT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_stall;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_mem [DEPTH];
   logic [31:0] last_rdata;
   logic        last_err;

   data_mem_responder #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_stall  (mem_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
   endtask

   // Reset for three edges, then release and expect an immediately ready DUT
   task automatic do_reset();
      reset     = 1'b1;
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", {31'h0, req_ready}, 32'h0);
      chk("rst_valid", {31'h0, resp_valid}, 32'h0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err",   {31'h0, resp_err}, 32'h0);
      reset = 1'b0;
      #1;
      chk("ready_after_rst", {31'h0, req_ready}, 32'h1);
      model_clear();
   endtask

   // One complete access; req_valid held until the response cycle
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      logic        mis;
      int          idx;
      logic [31:0] exp_rdata;
      bit          got;
      int          k;

      mis       = (addr[1:0] != 2'b00);
      idx       = int'((addr >> 2) % DEPTH);
      exp_rdata = (we || mis) ? 32'h0 : model_mem[idx];
      if (we && !mis) model_mem[idx] = wdata;

      chk("idle_ready", {31'h0, req_ready}, 32'h1);
      chk("idle_valid", {31'h0, resp_valid}, 32'h0);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      #1;
      chk("stall_req", {31'h0, mem_stall}, 32'h1);

      got = 1'b0;
      k   = 0;
      while (!got && k < 40) begin
         @(negedge clk);
         k++;
         if (resp_valid) begin
            got = 1'b1;
         end else begin
            chk("stall_wait", {31'h0, mem_stall}, 32'h1);
            chk("wait_ready", {31'h0, req_ready}, 32'h0);
            chk("wait_rdata", resp_rdata, 32'h0);
            chk("wait_err",   {31'h0, resp_err}, 32'h0);
            // Inputs moving while the access is in flight must not matter
            req_we    = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
         end
      end
      chk("resp_seen", {31'h0, got}, 32'h1);
      last_rdata = resp_rdata;
      last_err   = resp_err;
      if (got) begin
         chk("latency",    k, LAT + 1);
         chk("resp_rdata", resp_rdata, exp_rdata);
         chk("resp_err",   {31'h0, resp_err}, {31'h0, mis});
         chk("resp_stall", {31'h0, mem_stall}, 32'h0);
         chk("resp_ready", {31'h0, req_ready}, 32'h0);
      end
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(negedge clk);
      chk("post_valid", {31'h0, resp_valid}, 32'h0);
      chk("post_rdata", resp_rdata, 32'h0);
      chk("post_err",   {31'h0, resp_err}, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      model_clear();
      @(negedge clk);
      do_reset();

      // Fresh array reads zero
      access(1'b0, 32'h00, 32'h0);
      chk("dir_load0", last_rdata, 32'h0);

      // Store then load same word
      access(1'b1, 32'h10, 32'hDEAD_BEEF);
      chk("dir_store_rdata", last_rdata, 32'h0);
      access(1'b0, 32'h10, 32'h0);
      chk("dir_load10", last_rdata, 32'hDEAD_BEEF);

      // Misaligned store reports error and writes nothing
      access(1'b1, 32'h06, 32'h1234_5678);
      chk("dir_mis_err", {31'h0, last_err}, 32'h1);
      access(1'b0, 32'h04, 32'h0);
      chk("dir_load04", last_rdata, 32'h0);

      // Address wrap modulo DEPTH*4
      access(1'b1, 32'h84, 32'hA5A5_A5A5);
      access(1'b0, 32'h04, 32'h0);
      chk("dir_wrap", last_rdata, 32'hA5A5_A5A5);

`ifdef DMEM_WAIT_STATES_EN
      begin
         bit seen;
         // Reset during the first WAIT cycle aborts the store
         req_valid = 1'b1;
         req_we    = 1'b1;
         req_addr  = 32'h08;
         req_wdata = 32'h55;
         @(negedge clk);
         chk("abort_wait_valid", {31'h0, resp_valid}, 32'h0);
         reset     = 1'b1;
         req_valid = 1'b0;
         seen      = 1'b0;
         repeat (LAT + 3) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
         end
         chk("abort_no_resp", {31'h0, seen}, 32'h0);
         reset = 1'b0;
         #1;
         chk("abort_ready", {31'h0, req_ready}, 32'h1);
         model_clear();
         access(1'b0, 32'h08, 32'h0);
         chk("abort_load08", last_rdata, 32'h0);
      end
`endif

      // Random traffic on a few hot words with random upper address bits
      for (int n = 0; n < 80; n++) begin
         a = ($urandom & 32'hFFFF_FF80) | (32'($urandom_range(0, 7)) << 2);
         if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
         access(1'($urandom_range(0, 1)), a, $urandom);
      end

      // Reset clears the array
      do_reset();
      access(1'b0, 32'h10, 32'h0);
      chk("rst_cleared", last_rdata, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
